// File: rtl/lane_scanner_pkg.sv
// Shared types and helpers for the four-lane round-robin scanner.
package lane_scanner_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef enum logic {IDLE, SCAN} state_t;

  function automatic logic [LANES-1:0] onehot4(input logic [SEL_W-1:0] s);
    onehot4 = 4'b0001 << s;
  endfunction

endpackage

// File: rtl/lane_scanner_slot_timer.sv
// Per-slot prescaler: counts 0..DIV-1 while running and flags the final cycle of a slot.
module slot_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic last
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST_PRE = PW'(DIV - 1);

  logic [PW-1:0] r_pre;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (clr) begin
      r_pre <= '0;
    end else if (run) begin
      r_pre <= last ? '0 : r_pre + 1'b1;
    end
  end

  assign last = (r_pre == LAST_PRE);

endmodule

// File: rtl/lane_scanner.sv
// Scans a coherent per-frame snapshot of four lanes onto one bus, DIV cycles per lane.
// Define LANE_SCANNER_BLANK_EN to blank the bus on the last cycle of every slot.
module lane_scanner
  import lane_scanner_pkg::*;
#(
  parameter int DW  = 8,
  parameter int DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DW-1:0]    in0,
  input  logic [DW-1:0]    in1,
  input  logic [DW-1:0]    in2,
  input  logic [DW-1:0]    in3,
  output logic [DW-1:0]    out,
  output logic [SEL_W-1:0] sel,
  output logic [LANES-1:0] sel_oh,
  output logic             frame_start
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(LANES - 1);

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic [DW-1:0]    r_shadow [LANES];
  logic             r_frameStart;

  logic             w_last;
  logic             w_run;
  logic             w_clr;
  logic             w_frameEnd;
  logic             w_load;
  logic             w_drive;
  logic [DW-1:0]    w_lanes [LANES];

  assign w_run      = (r_state == SCAN);
  assign w_clr      = (r_state == IDLE);
  assign w_frameEnd = w_run && w_last && (r_sel == LAST_SEL);
  assign w_load     = en && (w_clr || w_frameEnd);

  assign w_lanes[0] = in0;
  assign w_lanes[1] = in1;
  assign w_lanes[2] = in2;
  assign w_lanes[3] = in3;

  slot_timer #(.DIV(DIV)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (w_run),
    .clr   (w_clr),
    .last  (w_last)
  );

  // en only matters when idle or on the frame boundary, so a frame never truncates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_frameStart <= 1'b0;
    end else begin
      r_frameStart <= w_load;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_state <= SCAN;
            r_sel   <= '0;
          end
        end
        SCAN: begin
          if (w_last) begin
            r_sel <= r_sel + 1'b1;
            if (w_frameEnd && !en) begin
              r_state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (w_load) begin
      for (int i = 0; i < LANES; i++) begin
        r_shadow[i] <= w_lanes[i];
      end
    end
  end

`ifdef LANE_SCANNER_BLANK_EN
  assign w_drive = w_run && !w_last;
`else
  assign w_drive = w_run;
`endif

  assign out         = w_drive ? r_shadow[r_sel] : '0;
  assign sel_oh      = w_drive ? onehot4(r_sel) : '0;
  assign sel         = r_sel;
  assign frame_start = r_frameStart;

endmodule

// File: tb/tb_lane_scanner.sv
// Scoreboard bench for lane_scanner: driver pushes model expectations, monitor pops at negedge.
// Build with LANE_SCANNER_BLANK_EN defined to exercise the blanking variant at DIV=3.
module tb_lane_scanner;

`ifdef LANE_SCANNER_BLANK_EN
  localparam int DIV   = 3;
  localparam bit BLANK = 1'b1;
`else
  localparam int DIV   = 4;
  localparam bit BLANK = 1'b0;
`endif
  localparam int FRAME = 4 * DIV;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [7:0] in0   = '0;
  logic [7:0] in1   = '0;
  logic [7:0] in2   = '0;
  logic [7:0] in3   = '0;
  logic [7:0] out;
  logic [1:0] sel;
  logic [3:0] sel_oh;
  logic       frame_start;

  always #5 clk = ~clk;

  lane_scanner #(.DW(8), .DIV(DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .in0         (in0),
    .in1         (in1),
    .in2         (in2),
    .in3         (in3),
    .out         (out),
    .sel         (sel),
    .sel_oh      (sel_oh),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [7:0] out;
    logic [1:0] sel;
    logic [3:0] oh;
    logic       fs;
  } expect_t;

  expect_t expQ[$];
  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: a frame is a snapshot plus a cycle position within 4*DIV cycles.
  bit         mActive = 1'b0;
  logic [7:0] mSnap [4];
  int         mT = 0;

  function automatic void modelReset();
    mActive = 1'b0;
    mT = 0;
    for (int i = 0; i < 4; i++) mSnap[i] = '0;
  endfunction

  function automatic void modelEdge(input logic enVal, input logic [7:0] a, b, c, d);
    if (!mActive) begin
      if (enVal) begin
        mActive = 1'b1;
        mT = 0;
        mSnap[0] = a; mSnap[1] = b; mSnap[2] = c; mSnap[3] = d;
      end
    end else if (mT == FRAME - 1) begin
      if (enVal) begin
        mT = 0;
        mSnap[0] = a; mSnap[1] = b; mSnap[2] = c; mSnap[3] = d;
      end else begin
        mActive = 1'b0;
      end
    end else begin
      mT++;
    end
  endfunction

  function automatic expect_t modelOutput();
    expect_t e;
    int slot;
    int phase;
    e = '0;
    if (mActive) begin
      slot  = mT / DIV;
      phase = mT % DIV;
      e.sel = 2'(slot);
      e.fs  = (mT == 0);
      if (!(BLANK && phase == DIV - 1)) begin
        e.out = mSnap[slot];
        e.oh  = 4'(1 << slot);
      end
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic enVal, input logic [7:0] a, b, c, d, input bit pulse);
    en = enVal; in0 = a; in1 = b; in2 = c; in3 = d;
    @(posedge clk);
    #1;
    if (!rst_n) modelReset();
    else modelEdge(enVal, a, b, c, d);
    if (pulse) begin
      rst_n = 1'b0;
      modelReset();
      expQ.push_back(modelOutput());
      #6;
      rst_n = 1'b1;
    end else begin
      expQ.push_back(modelOutput());
    end
  endtask

  task automatic checkOutput(input expect_t e);
    checks++;
    if (out !== e.out) begin
      errors++;
      $display("[TB] FAIL out cycle %0d: got %h expected %h", cycle, out, e.out);
    end
    checks++;
    if (sel !== e.sel) begin
      errors++;
      $display("[TB] FAIL sel cycle %0d: got %0d expected %0d", cycle, sel, e.sel);
    end
    checks++;
    if (sel_oh !== e.oh) begin
      errors++;
      $display("[TB] FAIL sel_oh cycle %0d: got %b expected %b", cycle, sel_oh, e.oh);
    end
    checks++;
    if (frame_start !== e.fs) begin
      errors++;
      $display("[TB] FAIL frame_start cycle %0d: got %b expected %b", cycle, frame_start, e.fs);
    end
  endtask

  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      cycle++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic timeoutFail(input string what);
    checks++;
    errors++;
    $display("[TB] FAIL timeout %s: got no match expected within bound", what);
  endtask

  initial begin
    int guard;
    bit enR;
    bit pulseR;

    $display("[TB] lane_scanner bench, DIV=%0d blank=%0d", DIV, BLANK);
    rst_n = 1'b0;
    modelReset();
    repeat (4) applyStimulus(1'b1, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 1'b0);
    rst_n = 1'b1;

    applyStimulus(1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    applyStimulus(1'b1, 8'h11, 8'hAA, 8'h33, 8'h44, 1'b0);
    repeat (3 * FRAME) applyStimulus(1'b1, 8'h11, 8'hAA, 8'h33, 8'h44, 1'b0);

    guard = 0;
    while (!(mActive && (mT / DIV) == 1) && guard < 2 * FRAME) begin
      applyStimulus(1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
      guard++;
    end
    if (guard >= 2 * FRAME) timeoutFail("reach slot 1");
    repeat (FRAME + 4) applyStimulus(1'b0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 1'b0);

    guard = 0;
    while (!(mActive && mT == 2 * DIV + 1) && guard < 3 * FRAME) begin
      applyStimulus(1'b1, 8'h21, 8'h32, 8'h43, 8'h54, 1'b0);
      guard++;
    end
    if (guard >= 3 * FRAME) timeoutFail("reach slot 2");
    applyStimulus(1'b1, 8'h21, 8'h32, 8'h43, 8'h54, 1'b1);
    repeat (2 * FRAME) applyStimulus(1'b1, 8'h66, 8'h77, 8'h88, 8'h99, 1'b0);

    repeat (600) begin
      enR    = ($urandom_range(0, 9) != 0);
      pulseR = ($urandom_range(0, 149) == 0);
      applyStimulus(enR, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), pulseR);
    end

    repeat (3) @(negedge clk);
    if (expQ.size() != 0) timeoutFail("scoreboard drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
